icache_assoc: RTL and testbench

Parametrised set-associative instruction cache between the fetch stage and the MMU/bus read port. Physically addressed, read-only, one-word fetch per request. Hits return combinationally in the request cycle. Misses refill a whole line by burst, install it into a round-robin victim way, and return the requested word in the cycle the burst's last beat arrives. Adds a whole-cache invalidate for self-modifying-code fences.

---
 rtl/icache_pkg.sv | 37 +++
 rtl/icache_if.sv | 28 ++
 rtl/icache_way_ram.sv | 29 ++
 rtl/icache_assoc.sv | 196 +++++++++++++++++++
 tb/tb_icache_assoc.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
//   state_t : refill controller states
//   off_w / idx_w / tag_w : address field widths from geometry parameters
//   line_t  : one cache line (tag + words), sized for the largest legal geometry
package icache_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned MAX_LINE_WORDS = 32;
  localparam int unsigned WIDX_W         = 5;   // log2(MAX_LINE_WORDS)
  localparam int unsigned MAX_TAG_W      = 28;  // 30 - min offset bits - min index bits

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_t;

  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
    return 30 - off_w(line_words) - idx_w(sets);
  endfunction

  // Tags are zero-extended and unused words stay zero, so narrower
  // geometries simply leave constant upper bits for synthesis to drop.
  typedef struct packed {
    logic [MAX_TAG_W-1:0]                   tag;
    logic [MAX_LINE_WORDS-1:0][WORD_W-1:0] words;
  } line_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and MMU-side signals of the instruction cache.
//   master : fetch stage + MMU (drives requests and burst beats)
//   slave  : the cache
interface icache_if;

  logic        inst_en;
  logic [31:0] inst_addr;
  logic        inst_ok;
  logic [31:0] inst_data;
  logic        inv_all;
  logic [31:0] inst_addr_mmu;
  logic        inst_read_req;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        mmu_valid;
  logic        mmu_last;

  modport master (
    output inst_en, inst_addr, inv_all, inst_addr_ok, inst_read_data, mmu_valid, mmu_last,
    input  inst_ok, inst_data, inst_addr_mmu, inst_read_req
  );

  modport slave (
    input  inst_en, inst_addr, inv_all, inst_addr_ok, inst_read_data, mmu_valid, mmu_last,
    output inst_ok, inst_data, inst_addr_mmu, inst_read_req
  );

endinterface

// File: rtl/icache_way_ram.sv
// One cache way: SETS lines of tag + data, single port, async read, sync write.
//   clk   : clock
//   we    : write the line at addr
//   addr  : set index (shared by read and write)
//   wline : line to install
//   rline : line currently stored at addr
module icache_way_ram
  import icache_pkg::*;
#(
  parameter int unsigned SETS = 64
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [idx_w(SETS)-1:0]  addr,
  input  line_t                   wline,
  output line_t                   rline
);

  line_t mem [SETS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wline;
    end
  end

  assign rline = mem[addr];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative, read-only instruction cache with burst line refill.
//   clk, rst : clock, synchronous active-high reset
//   bus      : icache_if.slave -- fetch request/response, whole-cache
//              invalidate, and the MMU burst read port
// Hits answer combinationally; a miss refills the whole line into a victim
// way (first invalid, else per-set round-robin) and answers on the last beat.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int unsigned WAYS       = 2,
  parameter int unsigned SETS       = 64,
  parameter int unsigned LINE_WORDS = 16
) (
  input  logic     clk,
  input  logic     rst,
  icache_if.slave  bus
);

  localparam int unsigned OFF   = off_w(LINE_WORDS);
  localparam int unsigned IDX   = idx_w(SETS);
  localparam int unsigned TAG_W = tag_w(SETS, LINE_WORDS);
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned CNT_W = OFF + 1;

  state_t                                state;
  logic [29:0]                           cap_addr;
  logic [CNT_W-1:0]                      cnt;
  logic [MAX_LINE_WORDS-1:0][WORD_W-1:0] buf_words;
  logic                                  inv_pend;
  logic [SETS-1:0][WAYS-1:0]             valid;
  logic [SETS-1:0][WAY_W-1:0]            rr;
  logic                                  read_req_q;
  logic [31:0]                           addr_mmu_q;

  logic [OFF-1:0]   req_off, cap_off;
  logic [IDX-1:0]   req_idx, cap_idx, ram_idx;
  logic [TAG_W-1:0] req_tag, cap_tag;

  line_t             rline [WAYS];
  line_t             wline;
  logic [WAYS-1:0]   hit_way;
  logic [WAYS-1:0]   ram_we;
  logic [WORD_W-1:0] hit_word;
  logic [WAY_W-1:0]  victim;
  logic              victim_free;
  logic              hit_c, fill_done_c, inv_any_c;
  logic              unused_addr_lsb;

  // Address fields of the live request and of the captured miss
  assign req_off = bus.inst_addr[OFF+1:2];
  assign req_idx = bus.inst_addr[OFF+IDX+1:OFF+2];
  assign req_tag = bus.inst_addr[31:OFF+IDX+2];
  assign cap_off = cap_addr[OFF-1:0];
  assign cap_idx = cap_addr[OFF+IDX-1:OFF];
  assign cap_tag = cap_addr[29:OFF+IDX];
  assign unused_addr_lsb = ^bus.inst_addr[1:0];

  // Single-port RAMs: look up the request in IDLE, otherwise address the refill set
  assign ram_idx = (state == IDLE) ? req_idx : cap_idx;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_ram #(.SETS(SETS)) u_ram (
      .clk   (clk),
      .we    (ram_we[w]),
      .addr  (ram_idx),
      .wline (wline),
      .rline (rline[w])
    );
  end

  // Tag compare and word select across all ways
  always_comb begin
    hit_way  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_way[w] = valid[req_idx][w] && (rline[w].tag == MAX_TAG_W'(req_tag));
      if (hit_way[w]) begin
        hit_word = hit_word | rline[w].words[WIDX_W'(req_off)];
      end
    end
  end

  assign hit_c       = (state == IDLE) && bus.inst_en && !bus.inv_all && (|hit_way);
  assign fill_done_c = (state == FILL) && bus.mmu_valid && bus.mmu_last;
  assign inv_any_c   = inv_pend || bus.inv_all;

  // Line to install: buffered beats with the final beat merged in
  always_comb begin
    wline       = '0;
    wline.tag   = MAX_TAG_W'(cap_tag);
    wline.words = buf_words;
    if (!cnt[OFF]) begin
      wline.words[WIDX_W'(cnt[OFF-1:0])] = bus.inst_read_data;
    end
  end

  // Victim: lowest invalid way, else the set's round-robin pointer
  always_comb begin
    victim      = rr[cap_idx];
    victim_free = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!victim_free && !valid[cap_idx][w]) begin
        victim      = WAY_W'(w);
        victim_free = 1'b1;
      end
    end
  end

  always_comb begin
    ram_we = '0;
    for (int w = 0; w < WAYS; w++) begin
      ram_we[w] = fill_done_c && !inv_any_c && (victim == WAY_W'(w));
    end
  end

  // Fetch response: hit in IDLE, or the captured word on the last beat
  always_comb begin
    bus.inst_ok   = 1'b0;
    bus.inst_data = '0;
    if (hit_c) begin
      bus.inst_ok   = 1'b1;
      bus.inst_data = hit_word;
    end else if (fill_done_c && bus.inst_en) begin
      bus.inst_ok   = 1'b1;
      bus.inst_data = wline.words[WIDX_W'(cap_off)];
    end
  end

  assign bus.inst_read_req = read_req_q;
  assign bus.inst_addr_mmu = addr_mmu_q;

  // Refill controller, valid bits and round-robin pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cnt        <= '0;
      buf_words  <= '0;
      inv_pend   <= 1'b0;
      valid      <= '0;
      rr         <= '0;
      read_req_q <= 1'b0;
      addr_mmu_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv_all) begin
            valid <= '0;
          end else if (bus.inst_en && !(|hit_way)) begin
            cap_addr   <= bus.inst_addr[31:2];
            read_req_q <= 1'b1;
            addr_mmu_q <= {bus.inst_addr[31:OFF+2], {(OFF+2){1'b0}}};
            state      <= REQ;
          end
        end
        REQ: begin
          if (bus.inv_all) begin
            inv_pend <= 1'b1;
          end
          if (bus.inst_addr_ok) begin
            read_req_q <= 1'b0;
            addr_mmu_q <= '0;
            cnt        <= '0;
            buf_words  <= '0;
            state      <= FILL;
          end
        end
        FILL: begin
          if (bus.inv_all) begin
            inv_pend <= 1'b1;
          end
          if (bus.mmu_valid) begin
            // Counter saturates at LINE_WORDS; surplus beats are dropped
            if (!cnt[OFF]) begin
              buf_words[WIDX_W'(cnt[OFF-1:0])] <= bus.inst_read_data;
              cnt <= cnt + CNT_W'(1);
            end
            if (bus.mmu_last) begin
              state    <= IDLE;
              inv_pend <= 1'b0;
              if (inv_any_c) begin
                valid <= '0;
              end else begin
                valid[cap_idx][victim] <= 1'b1;
                rr[cap_idx] <= (rr[cap_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                 : rr[cap_idx] + WAY_W'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Directed bench for icache_assoc (WAYS=2, SETS=64, LINE_WORDS=16).
// Stimulus pushes the expected fetch word into a queue; a monitor pops and
// compares whenever the cache raises inst_ok.
module tb_icache_assoc;

  import icache_pkg::*;

  localparam int LW = 16;

  logic clk = 1'b0;
  logic rst;

  icache_if bus ();

  icache_assoc #(
    .WAYS       (2),
    .SETS       (64),
    .LINE_WORDS (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.inst_ok === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: inst_ok with data %h, expected no response (t=%0t)",
                   bus.inst_data, $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_data", bus.inst_data, e);
        end
      end
    end
  end

  // Miss + full refill. drop_beat >= 0 lowers inst_en at that beat (no response);
  // inv_beat >= 0 pulses inv_all at that beat; junk drives stray beats during REQ.
  task automatic do_miss(input logic [31:0] addr, input logic [31:0] mmu,
                         input logic [31:0] base, input logic [31:0] exp,
                         input int delay, input bit junk,
                         input int inv_beat, input int drop_beat);
    bit want_ok;
    want_ok = (drop_beat < 0);
    if (want_ok) sb_q.push_back(exp);
    bus.inst_en   = 1'b1;
    bus.inst_addr = addr;
    @(negedge clk);
    chk("miss_no_hit", 32'(bus.inst_ok), 32'd0);
    cyc();
    for (int i = 0; i <= delay; i++) begin
      if (i == delay) begin
        bus.inst_addr_ok   = 1'b1;
        bus.mmu_valid      = 1'b0;
        bus.inst_read_data = '0;
      end else if (junk) begin
        bus.mmu_valid      = 1'b1;
        bus.inst_read_data = 32'hDEAD_0000 + 32'(i);
      end
      @(negedge clk);
      chk("req_held", 32'(bus.inst_read_req), 32'd1);
      chk("req_addr", bus.inst_addr_mmu, mmu);
      cyc();
    end
    bus.inst_addr_ok = 1'b0;
    for (int k = 0; k < LW; k++) begin
      bus.mmu_valid      = 1'b1;
      bus.inst_read_data = base + 32'(k);
      bus.mmu_last       = (k == LW - 1);
      bus.inv_all        = (k == inv_beat);
      if (k == drop_beat) bus.inst_en = 1'b0;
      @(negedge clk);
      chk("ok_on_last", 32'(bus.inst_ok), 32'(want_ok && (k == LW - 1)));
      cyc();
    end
    bus.mmu_valid      = 1'b0;
    bus.mmu_last       = 1'b0;
    bus.inv_all        = 1'b0;
    bus.inst_read_data = '0;
    bus.inst_en        = 1'b0;
  endtask

  task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
    sb_q.push_back(exp);
    bus.inst_en   = 1'b1;
    bus.inst_addr = addr;
    @(negedge clk);
    chk("hit_same_cycle", 32'(bus.inst_ok), 32'd1);
    cyc();
    bus.inst_en = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ok"},   32'(bus.inst_ok), 32'd0);
    chk({tag, "_data"}, bus.inst_data, 32'd0);
    chk({tag, "_req"},  32'(bus.inst_read_req), 32'd0);
    chk({tag, "_mmu"},  bus.inst_addr_mmu, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                = 1'b1;
    bus.inst_en        = 1'b0;
    bus.inst_addr      = '0;
    bus.inv_all        = 1'b0;
    bus.inst_addr_ok   = 1'b0;
    bus.inst_read_data = '0;
    bus.mmu_valid      = 1'b0;
    bus.mmu_last       = 1'b0;
    repeat (2) cyc();
    @(negedge clk);
    chk_idle_outputs("reset");
    cyc();
    rst = 1'b0;
    cyc();

    // Cold miss, then same-line hits
    do_miss(32'h0000_1044, 32'h0000_1040, 32'hA0, 32'hA1, 1, 1'b0, -1, -1);
    do_hit(32'h0000_1048, 32'hA2);
    do_hit(32'h0000_107C, 32'hAF);

    // inv_all in IDLE suppresses the hit and empties the cache
    bus.inst_en   = 1'b1;
    bus.inst_addr = 32'h0000_1048;
    bus.inv_all   = 1'b1;
    @(negedge clk);
    chk("inv_idle_suppress", 32'(bus.inst_ok), 32'd0);
    cyc();
    bus.inv_all = 1'b0;
    bus.inst_en = 1'b0;
    do_miss(32'h0000_1048, 32'h0000_1040, 32'hB0, 32'hB2, 0, 1'b0, -1, -1);

    // Fresh state for the eviction sequence
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    // Set 1: last-beat forward, two more fills, third evicts way 0
    do_miss(32'h0000_007C, 32'h0000_0040, 32'h500, 32'h50F, 2, 1'b0, -1, -1);
    do_miss(32'h0000_1040, 32'h0000_1040, 32'h200, 32'h200, 0, 1'b0, -1, -1);
    do_miss(32'h0000_2040, 32'h0000_2040, 32'h300, 32'h300, 0, 1'b0, -1, -1);
    do_hit(32'h0000_1044, 32'h201);
    do_hit(32'h0000_2048, 32'h302);
    do_miss(32'h0000_0040, 32'h0000_0040, 32'h400, 32'h400, 0, 1'b0, -1, -1);

    // inv_all during FILL: response returned, nothing installed, cache emptied
    do_miss(32'h0000_0088, 32'h0000_0080, 32'h600, 32'h602, 0, 1'b0, 3, -1);
    do_miss(32'h0000_0088, 32'h0000_0080, 32'h700, 32'h702, 0, 1'b0, -1, -1);
    do_hit(32'h0000_0084, 32'h701);
    do_miss(32'h0000_2048, 32'h0000_2040, 32'h780, 32'h782, 0, 1'b0, -1, -1);

    // Slow handshake with stray beats before acceptance
    do_miss(32'h0000_3000, 32'h0000_3000, 32'h800, 32'h800, 5, 1'b1, -1, -1);

    // Fetch withdrawn mid-fill: no response, line still installed
    do_miss(32'h0000_4010, 32'h0000_4000, 32'h900, 32'h904, 0, 1'b0, -1, 2);
    do_hit(32'h0000_4014, 32'h905);

    // Reset in the middle of a fill
    bus.inst_en   = 1'b1;
    bus.inst_addr = 32'h0000_5000;
    cyc();
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.mmu_valid      = 1'b1;
      bus.inst_read_data = 32'hF00 + 32'(k);
      cyc();
    end
    bus.mmu_valid      = 1'b0;
    bus.inst_read_data = '0;
    bus.inst_en        = 1'b0;
    rst                = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_fill");
    cyc();
    do_miss(32'h0000_5000, 32'h0000_5000, 32'hA00, 32'hA00, 1, 1'b0, -1, -1);

    repeat (2) cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
